// File: rtl/cache_refill_pkg.sv
// cache_refill_pkg: shared types and helpers for the refill line collector
`ifndef VC_MEM_RESP_MSG_TYPE_WRITE
`define VC_MEM_RESP_MSG_TYPE_WRITE 3'd1
`endif
package cache_refill_pkg;
  localparam logic [2:0] RESP_WR = `VC_MEM_RESP_MSG_TYPE_WRITE;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  typedef logic [31:0] word_t;
  function automatic int idx_w(input int line_words);
    return $clog2(line_words);
  endfunction
endpackage

// File: rtl/cache_refill_line_collector_dpath.sv
// cache_refill_line_collector_dpath: line register bank, arrival bitmap, word counter and duplicate flag
module cache_refill_line_collector_dpath
  import cache_refill_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LINE_WORDS = 16,
  localparam int IW = idx_w(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [IW-1:0]                idx,
  input  logic [WORD_W-1:0]            data,
  output logic                         seen,
  output logic                         last,
  output logic [WORD_W*LINE_WORDS-1:0] line_data,
  output logic                         line_dup
);
  logic [LINE_WORDS-1:0] bitmap;
  logic [IW:0] count;
  assign seen = bitmap[idx];
  // a repeated index overwrites its slot but never advances the count
  assign last = wr_en && !seen && count == (IW+1)'(LINE_WORDS-1);
  always_ff @(posedge clk)
    if (reset || clear) begin
      bitmap <= '0;
      count <= '0;
      line_data <= '0;
      line_dup <= 1'b0;
    end else if (wr_en) begin
      bitmap[idx] <= 1'b1;
      line_data[idx*WORD_W +: WORD_W] <= data;
      count <= count + {{IW{1'b0}}, !seen};
      line_dup <= line_dup | seen;
    end
endmodule

// File: rtl/cache_refill_line_collector.sv
// cache_refill_line_collector: assembles out-of-order memory read responses into one cache line
// CACHE_REFILL_CRIT_WORD_EN adds early forwarding of the critical word (crit_idx/crit_val/crit_data)
module cache_refill_line_collector
  import cache_refill_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LINE_WORDS = 16,
  parameter int OPQ_W = 8,
  localparam int IW = idx_w(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_val,
  output logic                         start_rdy,
  input  logic                         resp_val,
  output logic                         resp_rdy,
  input  logic [2:0]                   resp_type,
  input  logic [OPQ_W-1:0]             resp_opaque,
  input  logic [WORD_W-1:0]            resp_data,
  output logic                         line_val,
  input  logic                         line_rdy,
  output logic [WORD_W*LINE_WORDS-1:0] line_data,
  output logic                         line_dup
`ifdef CACHE_REFILL_CRIT_WORD_EN
  ,
  input  logic [IW-1:0]                crit_idx,
  output logic                         crit_val,
  output logic [WORD_W-1:0]            crit_data
`endif
);
  state_t state;
  logic is_wr, rd_acc, seen, last, unused_opq;
  logic [IW-1:0] idx;
  assign is_wr = resp_type == RESP_WR;
  assign idx = resp_opaque[IW-1:0];
  assign unused_opq = ^resp_opaque;
  assign start_rdy = state == IDLE;
  assign line_val = state == DONE;
  // write acks are always drained; reads only while collecting
  assign resp_rdy = state == COLLECT || is_wr;
  assign rd_acc = state == COLLECT && resp_val && !is_wr;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else if (state == IDLE && start_val) state <= COLLECT;
    else if (state == COLLECT && last) state <= DONE;
    else if (state == DONE && line_rdy) state <= IDLE;
  cache_refill_line_collector_dpath #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) u_dpath (
    .clk(clk),
    .reset(reset),
    .clear(start_rdy && start_val),
    .wr_en(rd_acc),
    .idx(idx),
    .data(resp_data),
    .seen(seen),
    .last(last),
    .line_data(line_data),
    .line_dup(line_dup)
  );
`ifdef CACHE_REFILL_CRIT_WORD_EN
  logic [IW-1:0] crit_q;
  always_ff @(posedge clk)
    if (reset) crit_q <= '0;
    else if (start_rdy && start_val) crit_q <= crit_idx;
  assign crit_val = rd_acc && !seen && idx == crit_q;
  assign crit_data = resp_data;
`endif
endmodule

// File: tb/tb_cache_refill_line_collector.sv
// tb_cache_refill_line_collector: directed stimulus checked against a spec-level line model every cycle
module tb_cache_refill_line_collector;
  import cache_refill_pkg::*;
  localparam int WW = 32, LW = 16, OW = 8, IW = $clog2(LW), LB = WW * LW;
  logic clk = 0, reset = 1, start_val = 0, resp_val = 0, line_rdy = 0;
  logic [2:0] resp_type = 0;
  logic [OW-1:0] resp_opaque = 0;
  logic [WW-1:0] resp_data = 0;
  logic start_rdy, resp_rdy, line_val, line_dup;
  logic [LB-1:0] line_data;
  int n_chk = 0, n_fail = 0;
  int phase = 0;
  logic [WW-1:0] m_words[LW];
  bit m_seen[LW];
  bit m_dup;
`ifdef CACHE_REFILL_CRIT_WORD_EN
  logic [IW-1:0] crit_idx = 0, m_crit;
  logic crit_val;
  logic [WW-1:0] crit_data;
  int n_crit = 0;
`endif
  always #5 clk = ~clk;

  cache_refill_line_collector #(.WORD_W(WW), .LINE_WORDS(LW), .OPQ_W(OW)) dut (
    .clk(clk), .reset(reset), .start_val(start_val), .start_rdy(start_rdy),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type), .resp_opaque(resp_opaque),
    .resp_data(resp_data), .line_val(line_val), .line_rdy(line_rdy), .line_data(line_data),
    .line_dup(line_dup)
`ifdef CACHE_REFILL_CRIT_WORD_EN
    , .crit_idx(crit_idx), .crit_val(crit_val), .crit_data(crit_data)
`endif
  );

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] m_line();
    logic [LB-1:0] l = '0;
    for (int i = 0; i < LW; i++) l[i*WW +: WW] = m_words[i];
    return l;
  endfunction

  function automatic logic [LB-1:0] lit_line(input logic [WW-1:0] base);
    logic [LB-1:0] l = '0;
    for (int i = 0; i < LW; i++) l[i*WW +: WW] = base + WW'(i);
    return l;
  endfunction

  // model: phase 0 idle, 1 collecting, 2 line complete; line completes once every index has been seen
  always @(posedge clk) begin
    int idx, n;
    idx = int'(resp_opaque[IW-1:0]);
    if (reset || (phase == 0 && start_val)) begin
      phase = reset ? 0 : 1;
      m_dup = 0;
      for (int i = 0; i < LW; i++) begin m_words[i] = '0; m_seen[i] = 0; end
`ifdef CACHE_REFILL_CRIT_WORD_EN
      if (!reset) m_crit = crit_idx;
`endif
    end else if (phase == 1 && resp_val && resp_type != RESP_WR) begin
      if (m_seen[idx]) m_dup = 1;
      m_seen[idx] = 1;
      m_words[idx] = resp_data;
      n = 0;
      for (int i = 0; i < LW; i++) n += int'(m_seen[i]);
      if (n == LW) phase = 2;
    end else if (phase == 2 && line_rdy) phase = 0;
  end

  always @(negedge clk) begin
    chk("start_rdy", start_rdy, phase == 0);
    chk("resp_rdy", resp_rdy, phase == 1 || resp_type == RESP_WR);
    chk("line_val", line_val, phase == 2);
    chk("line_dup", line_dup, m_dup);
    chk("line_data", line_data, m_line());
`ifdef CACHE_REFILL_CRIT_WORD_EN
    begin
      bit e;
      e = phase == 1 && resp_val && resp_type != RESP_WR && resp_opaque[IW-1:0] == m_crit
          && !m_seen[int'(resp_opaque[IW-1:0])];
      chk("crit_val", crit_val, e);
      if (e) chk("crit_data", crit_data, resp_data);
      if (crit_val) n_crit++;
    end
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input bit wr, input int idx, input logic [WW-1:0] d);
    bit ok = 0;
    resp_val = 1;
    resp_type = wr ? RESP_WR : 3'd0;
    resp_opaque = OW'(idx);
    resp_data = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = resp_rdy;
      tick();
    end
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL xfer_timeout: resp_rdy stayed %0b for idx %0d, required 1", resp_rdy, idx); end
    resp_val = 0;
    resp_type = 0;
  endtask

  task automatic start_line();
    bit ok = 0;
    start_val = 1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = start_rdy;
      tick();
    end
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL start_timeout: start_rdy stayed %0b, required 1", start_rdy); end
    start_val = 0;
  endtask

  task automatic take_line();
    line_rdy = 1;
    tick();
    line_rdy = 0;
    @(negedge clk);
    chk("idle_after_take", start_rdy, 1'b1);
    tick();
  endtask

  initial begin
    logic [LB-1:0] exp;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_start_rdy", start_rdy, 1'b1);
    chk("rst_line_val", line_val, 1'b0);
    chk("rst_resp_rdy", resp_rdy, 1'b0);
    chk("rst_line_data", line_data, '0);
    reset = 0;
    tick();
    // in-order line
    start_line();
    for (int i = 0; i < LW; i++) xfer(0, i, WW'('hA0 + i));
    @(negedge clk);
    chk("t1_line_val", line_val, 1'b1);
    chk("t1_line_data", line_data, lit_line('hA0));
    chk("t1_dup", line_dup, 1'b0);
    tick();
    take_line();
    // write ack in IDLE, reversed reads with gaps and interleaved acks, ack in DONE
    xfer(1, 0, 'hDEAD);
    start_line();
    for (int i = LW - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, 3)) tick();
      if (i % 5 == 0) xfer(1, i, 'hBEEF);
      xfer(0, i, WW'('hA0 + i));
    end
    xfer(1, 2, 'hCAFE);
    @(negedge clk);
    chk("t2_line_data", line_data, lit_line('hA0));
    chk("t2_line_val", line_val, 1'b1);
    tick();
    take_line();
    // duplicate index 3
    start_line();
    xfer(0, 3, 'h11);
    xfer(0, 3, 'h22);
    for (int i = 0; i < LW - 1; i++) if (i != 3) xfer(0, i, WW'('hB0 + i));
    @(negedge clk);
    chk("t4_not_done_16", line_val, 1'b0);
    tick();
    xfer(0, LW - 1, WW'('hB0 + LW - 1));
    @(negedge clk);
    exp = lit_line('hB0);
    exp[3*WW +: WW] = 'h22;
    chk("t4_line_data", line_data, exp);
    chk("t4_dup", line_dup, 1'b1);
    tick();
    // hold DONE with a read pending
    resp_val = 1;
    resp_opaque = 0;
    resp_data = 'hFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_stall_rdy", resp_rdy, 1'b0);
      chk("t5_hold_val", line_val, 1'b1);
      tick();
    end
    resp_val = 0;
    @(negedge clk);
    chk("t5_hold_data", line_data, exp);
    tick();
    take_line();
    // reset mid-line, then a fresh line
`ifdef CACHE_REFILL_CRIT_WORD_EN
    crit_idx = 5;
`endif
    start_line();
    for (int i = 0; i < 7; i++) xfer(0, i, WW'('hC0 + i));
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("t6_rst_data", line_data, '0);
    chk("t6_rst_val", line_val, 1'b0);
    chk("t6_rst_start", start_rdy, 1'b1);
`ifdef CACHE_REFILL_CRIT_WORD_EN
    n_crit = 0;
`endif
    tick();
    start_line();
    for (int i = 0; i < LW - 1; i++) xfer(0, i, WW'('h300 + i));
    xfer(0, 5, 'h305);
    xfer(0, LW - 1, WW'('h300 + LW - 1));
    @(negedge clk);
    chk("t6_line_data", line_data, lit_line('h300));
`ifdef CACHE_REFILL_CRIT_WORD_EN
    chk("t6_crit_pulses", n_crit, 1);
`endif
    tick();
    take_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal;
  end
endmodule
